debounce_scheduler: RTL and testbench

Shares one debounce engine across NUM_CH raw button inputs by visiting one channel per clock in round-robin order, keeping per-channel sample/counter/state registers. It produces a debounced level vector and a queue of press/release events, with a valid/ready handshake, for the sequence-acceptor logic downstream. It sits between the board button pins and the code-sequence recognizer and replaces per-button debouncer instances.

---
 rtl/debounce_scheduler.sv | 137 +++++++++++++
 tb/tb_debounce_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_scheduler.sv
// Time-multiplexed debouncer: one channel visited per clock in round-robin,
// debounced edges queued as {ch, press} events behind a valid/ready FIFO.
module debounce_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int STABLE_CNT = 16383,
  parameter int CNT_W      = 14,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [NUM_CH-1:0] raw,
  output logic [NUM_CH-1:0] debounced,
  output logic              evt_valid,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_press,
  input  logic              evt_ready,
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CNT);
  localparam logic [CH_W-1:0]  PTR_LAST = CH_W'(NUM_CH - 1);
  localparam logic [AW:0]      FULL_V   = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            press;
  } evt_t;

  logic [NUM_CH-1:0] sync1_q, sync2_q;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0] samp_q, samp_d;
  logic [NUM_CH-1:0] deb_q, deb_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  evt_t              mem_q [FIFO_DEPTH];
  evt_t              mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW:0]       count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              push;
  logic              pop;
  logic              full;
  logic              do_push;
  evt_t              push_evt;

  always_comb begin
    ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
  end

  // Only the channel under the scan pointer moves; the rest hold.
  always_comb begin
    samp_d         = samp_q;
    deb_d          = deb_q;
    cnt_d          = cnt_q;
    push           = 1'b0;
    push_evt.ch    = ptr_q;
    push_evt.press = samp_q[ptr_q];
    if (sync2_q[ptr_q] != samp_q[ptr_q]) begin
      samp_d[ptr_q] = sync2_q[ptr_q];
      cnt_d[ptr_q]  = '0;
    end else if (cnt_q[ptr_q] != STABLE_V) begin
      cnt_d[ptr_q] = cnt_q[ptr_q] + 1'b1;
    end else if (deb_q[ptr_q] != samp_q[ptr_q]) begin
      deb_d[ptr_q] = samp_q[ptr_q];
      push         = 1'b1;
    end
  end

  assign evt_valid = (count_q != '0);
  assign full      = (count_q == FULL_V);
  assign pop       = evt_valid && evt_ready;
  // A full queue still accepts when the head leaves on the same edge.
  assign do_push   = push && (!full || pop);

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q | (push & full & ~pop);
    if (do_push) begin
      mem_d[wr_q] = push_evt;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    unique case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sync1_q <= '0;
      sync2_q <= '0;
      ptr_q   <= '0;
      samp_q  <= '0;
      deb_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      ptr_q   <= ptr_d;
      samp_q  <= samp_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign debounced = deb_q;
  assign evt_ch    = mem_q[rd_q].ch;
  assign evt_press = mem_q[rd_q].press;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler (4 channels, STABLE_CNT=3, depth 4);
// expected events are queued by the stimulus and popped by a monitor.
module tb_debounce_scheduler;

  logic       clk = 1'b0;
  logic       reset_;
  logic [3:0] raw;
  logic [3:0] debounced;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic       evt_press;
  logic       evt_ready;
  logic       overflow;

  typedef struct {
    logic [1:0] ch;
    logic       press;
  } ev_t;

  ev_t exp_q [$];
  int  checks = 0;
  int  passed = 0;

  logic [1:0] tptr;

  always #5 clk = ~clk;

  debounce_scheduler #(
    .NUM_CH    (4),
    .STABLE_CNT(3),
    .CNT_W     (14),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset_   (reset_),
    .raw      (raw),
    .debounced(debounced),
    .evt_valid(evt_valid),
    .evt_ch   (evt_ch),
    .evt_press(evt_press),
    .evt_ready(evt_ready),
    .overflow (overflow)
  );

  // Channel that the next rising edge will visit.
  always @(posedge clk or negedge reset_) begin
    if (!reset_) tptr <= 2'd0;
    else         tptr <= tptr + 2'd1;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_visit(input logic [1:0] c);
    for (int i = 0; i < 4 && tptr != c; i++) @(negedge clk);
  endtask

  task automatic expect_ev(input logic [1:0] c, input logic p);
    ev_t e;
    e.ch    = c;
    e.press = p;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset_ === 1'b1 && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_event: got ch=%0d press=%0b expected none",
                   evt_ch, evt_press);
        end else begin
          e = exp_q.pop_front();
          check("evt_ch", 32'(evt_ch), 32'(e.ch));
          check("evt_press", 32'(evt_press), 32'(e.press));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end

  initial begin : stim
    reset_    = 1'b0;
    raw       = 4'hF;
    evt_ready = 1'b1;
    step(3);
    check("rst_deb", 32'(debounced), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_ch", 32'(evt_ch), 0);
    check("rst_press", 32'(evt_press), 0);
    check("rst_ovf", 32'(overflow), 0);

    // Release with all buttons held: s visible from edge 2, so ch2 first.
    reset_ = 1'b1;
    expect_ev(2'd2, 1'b1);
    expect_ev(2'd3, 1'b1);
    expect_ev(2'd0, 1'b1);
    expect_ev(2'd1, 1'b1);
    step(18);
    check("boot_deb18", 32'(debounced), 32'h0);
    step(1);
    check("boot_deb19", 32'(debounced), 32'h4);
    step(1);
    check("boot_deb20", 32'(debounced), 32'hC);
    step(1);
    check("boot_deb21", 32'(debounced), 32'hD);
    step(1);
    check("boot_deb22", 32'(debounced), 32'hF);
    step(2);
    check("boot_drained", 32'(evt_valid), 0);

    // Releases queue up, then a mid-run reset discards them.
    evt_ready = 1'b0;
    raw       = 4'h0;
    step(30);
    check("rel_deb", 32'(debounced), 32'h0);
    check("rel_valid", 32'(evt_valid), 1);
    reset_ = 1'b0;
    #1;
    check("midrst_valid", 32'(evt_valid), 0);
    step(2);
    reset_    = 1'b1;
    evt_ready = 1'b1;
    step(30);
    check("post_rst_deb", 32'(debounced), 32'h0);

    // Single press and release on ch2.
    raw[2] = 1'b1;
    expect_ev(2'd2, 1'b1);
    step(2);
    wait_visit(2'd2);
    step(16);
    check("press_pre", 32'(debounced), 32'h0);
    step(1);
    check("press_deb", 32'(debounced), 32'h4);
    check("press_valid", 32'(evt_valid), 1);
    step(1);
    check("press_1cyc", 32'(evt_valid), 0);
    raw[2] = 1'b0;
    expect_ev(2'd2, 1'b0);
    step(2);
    wait_visit(2'd2);
    step(16);
    check("rel2_pre", 32'(debounced), 32'h4);
    step(1);
    check("rel2_deb", 32'(debounced), 32'h0);
    step(2);

    // Bounce on ch1: 1,0,1 each seen at a ch1 visit, last visit L.
    wait_visit(2'd3);
    raw[1] = 1'b1;
    step(4);
    raw[1] = 1'b0;
    step(4);
    raw[1] = 1'b1;
    expect_ev(2'd1, 1'b1);
    step(3);
    step(15);
    check("bounce_pre", 32'(debounced), 32'h0);
    step(1);
    check("bounce_deb", 32'(debounced), 32'h2);
    step(2);

    // Backpressure: four edges fill the queue, the fifth is dropped.
    evt_ready = 1'b0;
    wait_visit(2'd2);
    raw = 4'b1101;
    expect_ev(2'd0, 1'b1);
    expect_ev(2'd1, 1'b0);
    expect_ev(2'd2, 1'b1);
    expect_ev(2'd3, 1'b1);
    step(25);
    check("bp_deb4", 32'(debounced), 32'hD);
    check("bp_ovf_pre", 32'(overflow), 0);
    raw[0] = 1'b0;
    step(25);
    check("bp_deb5", 32'(debounced), 32'hC);
    check("bp_ovf", 32'(overflow), 1);
    evt_ready = 1'b1;
    step(1);
    check("drain1", 32'(evt_valid), 1);
    step(1);
    check("drain2", 32'(evt_valid), 1);
    step(1);
    check("drain3", 32'(evt_valid), 1);
    step(1);
    check("drain4", 32'(evt_valid), 0);
    check("ovf_sticky", 32'(overflow), 1);

    // Full queue with push and pop on the same edge.
    reset_ = 1'b0;
    raw    = 4'h0;
    step(2);
    reset_ = 1'b1;
    check("ovf_cleared", 32'(overflow), 0);
    evt_ready = 1'b0;
    wait_visit(2'd2);
    raw = 4'hF;
    expect_ev(2'd0, 1'b1);
    expect_ev(2'd1, 1'b1);
    expect_ev(2'd2, 1'b1);
    expect_ev(2'd3, 1'b1);
    step(25);
    check("full_valid", 32'(evt_valid), 1);
    wait_visit(2'd2);
    raw[0] = 1'b0;
    expect_ev(2'd0, 1'b0);
    step(18);
    evt_ready = 1'b1;
    step(1);
    check("sim_ovf", 32'(overflow), 0);
    check("sim_deb", 32'(debounced), 32'hE);
    step(1);
    check("sim_d1", 32'(evt_valid), 1);
    step(1);
    check("sim_d2", 32'(evt_valid), 1);
    step(1);
    check("sim_d3", 32'(evt_valid), 1);
    step(1);
    check("sim_d4", 32'(evt_valid), 0);

    // One-cycle dip on ch3 that no ch3 visit sees.
    wait_visit(2'd3);
    raw[3] = 1'b0;
    step(1);
    raw[3] = 1'b1;
    step(24);
    check("glitch_deb", 32'(debounced), 32'hE);
    check("glitch_valid", 32'(evt_valid), 0);

    step(2);
    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
